// File: rtl/debug_key_gate.sv
// Debug key gate: forwards the key store to the debug module and scrubs it to zero around debug sessions.
// Latency: all outputs registered, one cycle; SCRUB_CYCLES of zero key before and after debug. Optional `DBG_LOCKOUT_EN.
// Backpressure: none; debug_req is a level hold, auth_valid is a one-cycle strobe.
module debug_key_gate #(
    parameter int               KEY_W        = 128,
    parameter int               SCRUB_CYCLES = 4,
    parameter logic [KEY_W-1:0] UNLOCK_TOKEN = 128'hA5A5_0F0F_5A5A_F0F0_1234_5678_9ABC_DEF0,
    parameter int               MAX_FAIL     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             debug_req,
    input  logic             auth_valid,
    input  logic [KEY_W-1:0] auth_token,
    input  logic             key_valid,
    input  logic [KEY_W-1:0] key_in,
    output logic [KEY_W-1:0] key_out,
    output logic             debug_mode,
    output logic             scrub_busy,
    output logic             auth_fail,
    output logic             locked
);

    localparam int               CNT_W      = (SCRUB_CYCLES > 1) ? $clog2(SCRUB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] SCRUB_LOAD = CNT_W'(SCRUB_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_AUTH,
        ST_SCRUB_IN,
        ST_DEBUG,
        ST_SCRUB_OUT
    } state_t;

    state_t           state_q;
    logic [KEY_W-1:0] key_q;
    logic [CNT_W-1:0] cnt_q;
    logic             debug_mode_q;
    logic             scrub_busy_q;
    logic             auth_fail_q;
    logic             retry_blk_q;
    logic             lock_hold;
    logic             auth_chk;
    logic             tok_ok;

    assign auth_chk = (state_q == ST_AUTH) && debug_req && auth_valid;
    assign tok_ok   = (auth_token == UNLOCK_TOKEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            key_q        <= '0;
            cnt_q        <= '0;
            debug_mode_q <= 1'b0;
            scrub_busy_q <= 1'b0;
            auth_fail_q  <= 1'b0;
            retry_blk_q  <= 1'b0;
        end else begin
            auth_fail_q <= 1'b0;
            // A rejected attempt blocks re-entry until debug_req has been seen low.
            if (!debug_req) begin
                retry_blk_q <= 1'b0;
            end
            if (((state_q == ST_IDLE) || (state_q == ST_AUTH)) && key_valid) begin
                key_q <= key_in;
            end
            case (state_q)
                ST_IDLE: begin
                    if (debug_req && !retry_blk_q && !lock_hold) begin
                        state_q <= ST_AUTH;
                    end
                end
                ST_AUTH: begin
                    if (!debug_req) begin
                        state_q <= ST_IDLE;
                    end else if (auth_chk && tok_ok) begin
                        state_q      <= ST_SCRUB_IN;
                        key_q        <= '0;
                        cnt_q        <= SCRUB_LOAD;
                        scrub_busy_q <= 1'b1;
                    end else if (auth_chk) begin
                        state_q     <= ST_IDLE;
                        auth_fail_q <= 1'b1;
                        retry_blk_q <= 1'b1;
                    end
                end
                ST_SCRUB_IN: begin
                    if (!debug_req) begin
                        state_q <= ST_SCRUB_OUT;
                        cnt_q   <= SCRUB_LOAD;
                    end else if (cnt_q == '0) begin
                        state_q      <= ST_DEBUG;
                        scrub_busy_q <= 1'b0;
                        debug_mode_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DEBUG: begin
                    if (!debug_req) begin
                        state_q      <= ST_SCRUB_OUT;
                        debug_mode_q <= 1'b0;
                        scrub_busy_q <= 1'b1;
                        cnt_q        <= SCRUB_LOAD;
                    end
                end
                ST_SCRUB_OUT: begin
                    if (cnt_q == '0) begin
                        state_q      <= ST_IDLE;
                        scrub_busy_q <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DBG_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAIL + 1);

    logic [FAIL_W-1:0] fail_cnt_q;
    logic              locked_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else if (auth_chk && tok_ok) begin
            fail_cnt_q <= '0;
        end else if (auth_chk) begin
            if (fail_cnt_q < FAIL_W'(MAX_FAIL)) begin
                fail_cnt_q <= fail_cnt_q + 1'b1;
            end
            if (fail_cnt_q >= FAIL_W'(MAX_FAIL - 1)) begin
                locked_q <= 1'b1;
            end
        end
    end

    assign lock_hold = locked_q;
    assign locked    = locked_q;
`else
    logic unused_cfg;
    assign unused_cfg = ^MAX_FAIL;
    assign lock_hold  = 1'b0;
    assign locked     = 1'b0;
`endif

    assign key_out    = key_q;
    assign debug_mode = debug_mode_q;
    assign scrub_busy = scrub_busy_q;
    assign auth_fail  = auth_fail_q;

endmodule

// File: tb/tb_debug_key_gate.sv
// Directed bench for debug_key_gate: reset, unlock, exit scrub, wrong token, aborted scrub, async reset, lockout.
module tb_debug_key_gate;

    localparam int         KEY_W = 128;
    localparam logic [127:0] TOK = 128'hA5A5_0F0F_5A5A_F0F0_1234_5678_9ABC_DEF0;
    localparam logic [127:0] K1  = {32{4'h1}};
    localparam logic [127:0] K2  = {32{4'h2}};
    localparam logic [127:0] K3  = {32{4'h3}};
    localparam logic [127:0] K4  = {32{4'h4}};
    localparam logic [127:0] K5  = {32{4'h5}};

    logic             clk = 1'b0;
    logic             rst_n;
    logic             debug_req;
    logic             auth_valid;
    logic [KEY_W-1:0] auth_token;
    logic             key_valid;
    logic [KEY_W-1:0] key_in;
    logic [KEY_W-1:0] key_out;
    logic             debug_mode;
    logic             scrub_busy;
    logic             auth_fail;
    logic             locked;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    debug_key_gate dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .debug_req (debug_req),
        .auth_valid(auth_valid),
        .auth_token(auth_token),
        .key_valid (key_valid),
        .key_in    (key_in),
        .key_out   (key_out),
        .debug_mode(debug_mode),
        .scrub_busy(scrub_busy),
        .auth_fail (auth_fail),
        .locked    (locked)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; debug_req = 1'b0; auth_valid = 1'b0; auth_token = '0;
        key_valid = 1'b1; key_in = K1;
        #2;
        checks++; if (key_out !== '0) begin failures++; $display("FAIL rst_key got=%h exp=0", key_out); end
        checks++; if ({debug_mode, scrub_busy, auth_fail, locked} !== 4'b0) begin
            failures++; $display("FAIL rst_flags got=%b exp=0000", {debug_mode, scrub_busy, auth_fail, locked}); end
        tick();
        checks++; if (key_out !== '0) begin failures++; $display("FAIL rst_key_clk got=%h exp=0", key_out); end
        rst_n = 1'b1;
        tick();
        checks++; if (key_out !== K1) begin failures++; $display("FAIL rst_fwd got=%h exp=%h", key_out, K1); end
    endtask

    task automatic test_unlock();
        debug_req = 1'b1;
        tick();
        checks++; if (key_out !== K1) begin failures++; $display("FAIL auth_fwd got=%h exp=%h", key_out, K1); end
        auth_valid = 1'b1; auth_token = TOK;
        tick();
        auth_valid = 1'b0; key_in = K2;
        checks++; if (key_out !== '0) begin failures++; $display("FAIL unlock_clr got=%h exp=0", key_out); end
        checks++; if ({scrub_busy, debug_mode} !== 2'b10) begin
            failures++; $display("FAIL unlock_n got=%b exp=10", {scrub_busy, debug_mode}); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if ({scrub_busy, debug_mode, key_out == '0} !== 3'b101) begin
                failures++; $display("FAIL scrub_in_%0d got=%b exp=101", i, {scrub_busy, debug_mode, key_out == '0}); end
        end
        tick();
        checks++; if ({scrub_busy, debug_mode} !== 2'b01) begin
            failures++; $display("FAIL debug_entry got=%b exp=01", {scrub_busy, debug_mode}); end
        auth_valid = 1'b1; auth_token = '0;
        tick();
        auth_valid = 1'b0;
        tick();
        checks++; if ({key_out, debug_mode, auth_fail} !== {128'h0, 1'b1, 1'b0}) begin
            failures++; $display("FAIL debug_hold key=%h dm=%b af=%b exp key=0 dm=1 af=0", key_out, debug_mode, auth_fail); end
    endtask

    task automatic test_exit();
        debug_req = 1'b0;
        tick();
        checks++; if ({debug_mode, scrub_busy} !== 2'b01) begin
            failures++; $display("FAIL exit_m got=%b exp=01", {debug_mode, scrub_busy}); end
        for (int i = 1; i < 4; i++) begin
            tick();
            checks++; if ({scrub_busy, key_out == '0} !== 2'b11) begin
                failures++; $display("FAIL scrub_out_%0d got=%b exp=11", i, {scrub_busy, key_out == '0}); end
        end
        tick();
        checks++; if ({scrub_busy, key_out == '0} !== 2'b01) begin
            failures++; $display("FAIL exit_idle got=%b exp=01", {scrub_busy, key_out == '0}); end
        tick();
        checks++; if (key_out !== K2) begin failures++; $display("FAIL exit_refresh got=%h exp=%h", key_out, K2); end
    endtask

    task automatic test_wrong_token();
        auth_valid = 1'b1; auth_token = TOK;
        tick();
        auth_valid = 1'b0;
        checks++; if (scrub_busy !== 1'b0) begin failures++; $display("FAIL idle_ignore got=%b exp=0", scrub_busy); end
        debug_req = 1'b1; key_in = K3;
        tick();
        auth_valid = 1'b1; auth_token = '0;
        tick();
        auth_valid = 1'b0;
        checks++; if ({auth_fail, key_out} !== {1'b1, K3}) begin
            failures++; $display("FAIL wrong_pulse af=%b key=%h exp af=1 key=%h", auth_fail, key_out, K3); end
        tick();
        checks++; if ({auth_fail, debug_mode, scrub_busy} !== 3'b000) begin
            failures++; $display("FAIL wrong_after got=%b exp=000", {auth_fail, debug_mode, scrub_busy}); end
        tick();
        auth_valid = 1'b1; auth_token = TOK;
        tick();
        auth_valid = 1'b0;
        tick();
        checks++; if ({scrub_busy, debug_mode, key_out} !== {2'b00, K3}) begin
            failures++; $display("FAIL rearm_block sb=%b dm=%b key=%h exp sb=0 dm=0 key=%h", scrub_busy, debug_mode, key_out, K3); end
        debug_req = 1'b0;
        tick();
    endtask

    task automatic test_abort_scrub();
        debug_req = 1'b1;
        tick();
        auth_valid = 1'b1; auth_token = TOK;
        tick();
        auth_valid = 1'b0;
        tick();
        tick();
        debug_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if ({scrub_busy, debug_mode, key_out == '0} !== 3'b101) begin
                failures++; $display("FAIL abort_%0d got=%b exp=101", i, {scrub_busy, debug_mode, key_out == '0}); end
        end
        tick();
        checks++; if ({scrub_busy, debug_mode} !== 2'b00) begin
            failures++; $display("FAIL abort_idle got=%b exp=00", {scrub_busy, debug_mode}); end
        tick();
        checks++; if (key_out !== K3) begin failures++; $display("FAIL abort_refresh got=%h exp=%h", key_out, K3); end
    endtask

    task automatic test_async_reset();
        debug_req = 1'b1;
        tick();
        auth_valid = 1'b1; auth_token = TOK;
        tick();
        auth_valid = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({scrub_busy, debug_mode, auth_fail, locked, key_out == '0} !== 5'b00001) begin
            failures++; $display("FAIL arst_scrub got=%b exp=00001", {scrub_busy, debug_mode, auth_fail, locked, key_out == '0}); end
        debug_req = 1'b0; key_in = K4;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if ({key_out, scrub_busy} !== {K4, 1'b0}) begin
            failures++; $display("FAIL arst_idle key=%h sb=%b exp key=%h sb=0", key_out, scrub_busy, K4); end
        debug_req = 1'b1;
        tick();
        auth_valid = 1'b1; auth_token = TOK;
        tick();
        auth_valid = 1'b0;
        repeat (4) tick();
        checks++; if (debug_mode !== 1'b1) begin failures++; $display("FAIL arst_pre_debug got=%b exp=1", debug_mode); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if ({scrub_busy, debug_mode, key_out == '0} !== 3'b001) begin
            failures++; $display("FAIL arst_debug got=%b exp=001", {scrub_busy, debug_mode, key_out == '0}); end
        debug_req = 1'b0; key_in = K5;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if ({key_out, debug_mode} !== {K5, 1'b0}) begin
            failures++; $display("FAIL arst_debug_idle key=%h dm=%b exp key=%h dm=0", key_out, debug_mode, K5); end
    endtask

`ifdef DBG_LOCKOUT_EN
    task automatic test_lockout();
        for (int i = 0; i < 3; i++) begin
            checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_early_%0d got=%b exp=0", i, locked); end
            debug_req = 1'b1;
            tick();
            auth_valid = 1'b1; auth_token = '0;
            tick();
            auth_valid = 1'b0; debug_req = 1'b0;
            tick();
        end
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_set got=%b exp=1", locked); end
        debug_req = 1'b1; key_in = K1;
        tick();
        auth_valid = 1'b1; auth_token = TOK;
        tick();
        auth_valid = 1'b0;
        tick();
        checks++; if ({scrub_busy, key_out} !== {1'b0, K1}) begin
            failures++; $display("FAIL lock_ignore sb=%b key=%h exp sb=0 key=%h", scrub_busy, key_out, K1); end
        debug_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL lock_clear got=%b exp=0", locked); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_unlock();
        test_exit();
        test_wrong_token();
        test_abort_scrub();
        test_async_reset();
`ifdef DBG_LOCKOUT_EN
        test_lockout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debug_key_gate.md
# debug_key_gate

Upstream gate for the sensitive debug module. It owns the path from the key store to that module's `secret_key` input and is the only source of its `debug_mode` input. Debug is granted only after a token challenge succeeds and the forwarded key has been scrubbed to zero for a fixed number of cycles. The key is not forwarded again until a post-debug scrub completes. As a result, the downstream stage only ever latches zero while in debug.

## Interface
- `KEY_W`, default 128: width of the key and auth-token buses.
- `SCRUB_CYCLES`, default 4: number of cycles the key is held at zero before debug entry and after debug exit (≥1).
- `UNLOCK_TOKEN`, default `128'hA5A5_0F0F_5A5A_F0F0_1234_5678_9ABC_DEF0`: token value that grants debug.
- `MAX_FAIL`, default 3: number of failed attempts that triggers lockout. Only used when `DBG_LOCKOUT_EN` is defined.

Ports:
- `clk` in 1: the block's single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `debug_req` in 1: level request for debug; debug lasts while this is held high.
- `auth_valid` in 1: one-cycle strobe qualifying `auth_token`.
- `auth_token` in `KEY_W`: presented unlock token.
- `key_valid` in 1: key store has a valid key on `key_in`.
- `key_in` in `KEY_W`: key from the key store.
- `key_out` out `KEY_W`: key to the downstream `secret_key` input.
- `debug_mode` out 1: drives the downstream `debug_mode` input.
- `scrub_busy` out 1: high during either scrub phase.
- `auth_fail` out 1: one-cycle pulse on a rejected token.
- `locked` out 1: lockout active. Tied to 0 when `DBG_LOCKOUT_EN` is not defined.

## Operation
- All outputs are registered.
- Reset values: `key_out`=0, `debug_mode`=0, `scrub_busy`=0, `auth_fail`=0, `locked`=0, state=IDLE, scrub counter=0, fail counter=0.

IDLE:
- `key_out` loads `key_in` on each cycle where `key_valid`=1; otherwise it holds its value.
- `debug_req`=1 moves the FSM to AUTH.

AUTH:
- `key_out` keeps forwarding as in IDLE.
- The FSM waits for `auth_valid`.
- If `debug_req` drops before a token arrives, the FSM returns to IDLE.
- Token equal to `UNLOCK_TOKEN`: go to SCRUB_IN, clear `key_out` to 0 on the same edge, and load the scrub counter with `SCRUB_CYCLES-1`.
- Token not equal: pulse `auth_fail` and return to IDLE. `debug_req` must then fall and rise again before a new AUTH.

SCRUB_IN:
- `key_out` is 0 and `scrub_busy`=1.
- The counter decrements each cycle. When it reaches 0, the FSM goes to DEBUG.
- If `debug_req` falls during SCRUB_IN, the FSM goes straight to SCRUB_OUT.

DEBUG:
- `debug_mode`=1 and `key_out` is 0.
- `key_valid` and `key_in` are ignored.
- `debug_req` falling moves the FSM to SCRUB_OUT, with `debug_mode` deasserted on that edge.

SCRUB_OUT:
- `key_out` is 0 and `scrub_busy`=1 for `SCRUB_CYCLES` cycles, then the FSM returns to IDLE.
- The first refresh of `key_out` happens on the first IDLE cycle that has `key_valid`=1.

General rules:
- `auth_valid` is ignored in every state except AUTH.
- Asserting `rst_n` low in any state immediately forces all outputs to their reset values. `key_out`=0 asynchronously, with no clock required.

## Timing
- Correct token at edge N: `key_out`=0 from N. `scrub_busy` is high for edges N through N+`SCRUB_CYCLES`-1. `debug_mode`=1 from edge N+`SCRUB_CYCLES`.
- `debug_req` low sampled at edge M while in DEBUG: `debug_mode`=0 from M. `scrub_busy` is high for `SCRUB_CYCLES` cycles. IDLE from M+`SCRUB_CYCLES`.
- `debug_mode` and a nonzero `key_out` are never high in the same cycle. The minimum separation between them is `SCRUB_CYCLES` cycles.
- `auth_fail` is a pulse one cycle after the rejected `auth_valid` edge.

## Configuration
- `DBG_LOCKOUT_EN` defined:
  - A saturating fail counter increments on each rejected token.
  - Reaching `MAX_FAIL` sets `locked`=1.
  - While locked, the FSM stays in IDLE, `debug_req` is ignored, and key forwarding continues.
  - Only `rst_n` clears `locked`.
  - A successful unlock clears the fail counter.
- `DBG_LOCKOUT_EN` not defined: no fail counter, `locked` is constant 0, and retries are unlimited.

## Test plan
- Reset with `key_valid`=1, `key_in`=`128'h1111…`: `key_out`=0 during reset, then `128'h1111…` one cycle after `rst_n` rises.
- `debug_req`=1 with correct `UNLOCK_TOKEN`: `key_out`=0 on the same edge, `scrub_busy` high for 4 cycles, `debug_mode`=1 on cycle 4. `key_out` stays 0 while `key_in` changes to `128'h2222…`.
- In DEBUG, drop `debug_req`: `debug_mode`=0 next edge, 4 cycles of `scrub_busy`, then `key_out`=`128'h2222…` on the first IDLE edge.
- Wrong token (`128'h0`): `auth_fail` pulses once, FSM returns to IDLE, `debug_mode` never rises, and `key_out` stays unscrubbed.
- With `DBG_LOCKOUT_EN`, 3 wrong tokens: `locked`=1, a following correct token is ignored, and `rst_n` pulse clears `locked`.
- Pull `rst_n` low mid-SCRUB_IN and mid-DEBUG: all outputs are 0 asynchronously, and the FSM is in IDLE after release.
